// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register: skid-stage state
// encoding and the default payload width.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b11
    } stage_st_e;

    localparam int PIPE_WIDTH_DEF = 32;

endpackage

// File: rtl/pipe_skid_stage.sv
// One skid-buffered handshake stage: main register feeds the output, the skid
// register catches the word accepted while the output is stalled.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    stage_st_e        r_st;
    stage_st_e        w_nxt_st;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_push;
    logic             w_pop;
    logic             w_ld_main;
    logic             w_main_from_skid;
    logic             w_ld_skid;

    // Ready depends only on registered state, so no path from i_ready to o_ready.
    assign o_ready = (r_st != ST_FULL);
    assign o_valid = (r_st != ST_EMPTY);
    assign o_data  = o_valid ? r_main : '0;
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    always_comb begin
        w_nxt_st         = r_st;
        w_ld_main        = 1'b0;
        w_main_from_skid = 1'b0;
        w_ld_skid        = 1'b0;
        case (r_st)
            ST_EMPTY: begin
                if (w_push) begin
                    w_nxt_st  = ST_BUSY;
                    w_ld_main = 1'b1;
                end
            end
            ST_BUSY: begin
                if (w_push && w_pop) begin
                    w_ld_main = 1'b1;
                end else if (w_push) begin
                    w_nxt_st  = ST_FULL;
                    w_ld_skid = 1'b1;
                end else if (w_pop) begin
                    w_nxt_st = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_nxt_st         = ST_BUSY;
                    w_ld_main        = 1'b1;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_nxt_st = ST_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_st   <= ST_EMPTY;
            r_main <= '0;
            r_skid <= '0;
        end else if (i_flush) begin
            r_st   <= ST_EMPTY;
            r_main <= '0;
            r_skid <= '0;
        end else begin
            r_st <= w_nxt_st;
            if (w_ld_main) r_main <= w_main_from_skid ? r_skid : i_data;
            if (w_ld_skid) r_skid <= i_data;
        end
    end

endmodule

// File: rtl/pipe_elastic_reg.sv
// DEPTH cascaded skid stages under valid/ready with synchronous flush.
// Optional back-pressure counter enabled by PIPE_ELASTIC_STALL_CNT_EN.
module pipe_elastic_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH_DEF,
    parameter int DEPTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    logic [DEPTH:0]            w_vld;
    logic [DEPTH:0]            w_rdy;
    logic [DEPTH:0][WIDTH-1:0] w_data;

    assign w_vld[0]    = in_valid_i;
    assign w_data[0]   = in_data_i;
    assign w_rdy[DEPTH] = out_ready_i;
    assign in_ready_o  = w_rdy[0];
    assign out_valid_o = w_vld[DEPTH];
    assign out_data_o  = w_data[DEPTH];

    // Valid/data flow forward through the chain, ready flows backward.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipe_skid_stage #(.WIDTH(WIDTH)) u_stage (
            .i_clk   (clk_i),
            .i_rst_n (rst_i),
            .i_flush (flush_i),
            .i_valid (w_vld[k]),
            .o_ready (w_rdy[k]),
            .i_data  (w_data[k]),
            .o_valid (w_vld[k+1]),
            .i_ready (w_rdy[k+1]),
            .o_data  (w_data[k+1])
        );
    end

`ifdef PIPE_ELASTIC_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturating; flush deliberately leaves it untouched.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
        end else if (out_valid_o && !out_ready_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Directed bench for pipe_elastic_reg (DEPTH=2, CNT_W=4) with a short
// randomized handshake phase checked against a FIFO scoreboard.
module tb_pipe_elastic_reg;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
`ifdef PIPE_ELASTIC_STALL_CNT_EN
    localparam logic [31:0] EXP_SAT = 32'd15;
`else
    localparam logic [31:0] EXP_SAT = 32'd0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] stall_cnt;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] sb_q[$];

    pipe_elastic_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .stall_cnt_o (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Book-keep both ports just before the edge, then advance one cycle.
    task automatic sb_cycle();
        logic [31:0] exp_d;
        if (in_valid && in_ready) sb_q.push_back(in_data);
        if (out_valid && out_ready) begin
            exp_d = (sb_q.size() > 0) ? sb_q.pop_front() : ~out_data;
            chk("rnd_data", out_data, exp_d);
        end else if (!out_valid) begin
            chk("rnd_gate", out_data, 32'h0);
        end
        step();
    endtask

    initial begin
        int acc;
        logic [31:0] d;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_stall", {28'b0, stall_cnt}, 32'd0);
        #10 rst_n = 1'b1;
        step();

        // Streaming: 1..16 back to back, first output after DEPTH edges, no gaps.
        for (int s = 1; s <= 16 + DEPTH + 1; s++) begin
            in_valid = (s <= 16);
            in_data  = s;
            step();
            chk("str_valid", {31'b0, out_valid}, {31'b0, (s >= DEPTH && s <= 15 + DEPTH)});
            chk("str_data", out_data, (s >= DEPTH && s <= 15 + DEPTH) ? s - DEPTH + 1 : 0);
        end
        in_valid = 1'b0;

        // Back-pressure fill: exactly 2*DEPTH accepts, then ready drops.
        out_ready = 1'b0;
        acc = 0; d = 1;
        for (int s = 0; s < 8; s++) begin
            in_valid = 1'b1;
            in_data  = d;
            if (in_ready) begin acc++; d++; end
            step();
        end
        in_valid = 1'b0;
        chk("fill_accepts", acc, 32'd4);
        chk("fill_in_ready", {31'b0, in_ready}, 32'd0);
        repeat (14) step();
        chk("stall_sat", {28'b0, stall_cnt}, EXP_SAT);

        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain_valid", {31'b0, out_valid}, 32'd1);
            chk("drain_data", out_data, k);
            step();
        end
        chk("drain_empty", {31'b0, out_valid}, 32'd0);
        chk("drain_ready", {31'b0, in_ready}, 32'd1);

        // Flush while full with a simultaneous push of 0x55.
        out_ready = 1'b0;
        for (int s = 0; s < 6; s++) begin
            in_valid = 1'b1; in_data = 32'h100 + s;
            step();
        end
        chk("pre_flush_full", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b1; in_data = 32'h55; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_data", out_data, 32'h0);
        chk("flush_ready", {31'b0, in_ready}, 32'd1);
        chk("flush_keeps_stall", {28'b0, stall_cnt}, EXP_SAT);
        out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            step();
            chk("flush_no_55", {31'b0, out_valid}, 32'd0);
        end
        in_valid = 1'b1; in_data = 32'h77;
        step();
        in_valid = 1'b0;
        step();
        chk("post_flush_valid", {31'b0, out_valid}, 32'd1);
        chk("post_flush_data", out_data, 32'h77);
        step();

        // Reset mid-stream with two entries held, then latency of a fresh push.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hB1; step();
        in_data = 32'hB2; step();
        in_valid = 1'b0;
        chk("held_valid", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_out_data", out_data, 32'h0);
        chk("mid_rst_stall", {28'b0, stall_cnt}, 32'd0);
        #1 rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'hA5A5A5A5;
        step();
        in_valid = 1'b0;
        chk("lat_early", {31'b0, out_valid}, 32'd0);
        step();
        chk("lat_valid", {31'b0, out_valid}, 32'd1);
        chk("lat_data", out_data, 32'hA5A5A5A5);
        step();

        // Random handshake against a FIFO scoreboard, then drain.
        sb_q.delete();
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            sb_cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4 * DEPTH + 4; c++) sb_cycle();
        chk("rnd_residual", sb_q.size(), 32'd0);
        chk("rnd_idle", {31'b0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_elastic_reg.md
# pipe_elastic_reg

Parametrised elastic pipeline register for the CPU pipeline and its memory side paths. It carries a WIDTH-bit payload through DEPTH skid-buffered stages under a valid/ready handshake, so that back-pressure never drops or duplicates data. It also provides a synchronous flush, with zeroing semantics, for branch and hazard squash. It is the handshaked successor to the plain write-enable/flush stage register and drops in between any two pipeline sections that need independent stall.

## Interface
Parameters:
- WIDTH, 32, payload width in bits (≥1)
- DEPTH, 1, number of cascaded stages (≥1)
- CNT_W, 16, stall counter width (only used with PIPE_ELASTIC_STALL_CNT_EN)

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset; asynchronous, active-low
- flush_i  in  1  synchronous squash of every stage
- in_valid_i  in  1  upstream payload valid
- in_ready_o  out  1  stage 0 can accept
- in_data_i  in  WIDTH  upstream payload
- out_valid_o  out  1  last stage holds valid payload
- out_ready_i  in  1  downstream accepts
- out_data_o  out  WIDTH  last-stage payload
- stall_cnt_o  out  CNT_W  saturating back-pressure cycle count (macro only)

## Operation
- **Transfer rule.** A transfer happens on an edge where valid and ready are both high, at either port.
- **Stage states.** Each stage has a main register and a skid register, each with its own valid bit.
  - EMPTY: neither register holds data.
  - BUSY: main holds data.
  - FULL: main and skid both hold data.
- **Per-stage ready.** ready_k = skid empty. This is a registered signal, with no combinational path from out_ready_i.
- **Transitions:**
  - EMPTY + push → BUSY
  - BUSY + push + pop → BUSY (main takes the new data)
  - BUSY + pop → EMPTY
  - BUSY + push, no pop → FULL (skid takes the new data)
  - FULL + pop → BUSY (skid moves to main, skid clears)
  - FULL never receives a push.
- **Ordering.** Strict FIFO order across all stages; no reordering or duplication.
- **Outputs.** out_valid_o and out_data_o come from the last stage's main register; in_ready_o is ready_0.
- **Flush.** flush_i=1 clears every valid bit and zeroes every main and skid data register on the next edge.
  - Flush wins over a simultaneous push or pop: input offered in a flush cycle is dropped.
  - Output consumed in a flush cycle counts as delivered once.
- **Reset.** All valid bits are 0 and all data registers are 0. Outputs: in_ready_o=1, out_valid_o=0, out_data_o=0, stall_cnt_o=0.
  - Reset asserted mid-transfer discards all contents immediately; no partial state survives.
- **Data gating.** out_data_o is 0 whenever out_valid_o=0.

## Timing
- Latency: DEPTH cycles from accepted input to out_valid_o, with an empty pipe and out_ready_i=1.
- Throughput: one transfer per cycle sustained.
- Buffering: 2×DEPTH entries. With out_ready_i held low, in_ready_o drops on the edge after the (2×DEPTH)th accept.
- Recovery: after out_ready_i rises, in_ready_o returns high one cycle later per stage of backlog propagation. The upper bound is DEPTH cycles.
- Flush: out_valid_o=0 and in_ready_o=1 on the edge after flush_i; new data is accepted in the following cycle.

## Configuration
- PIPE_ELASTIC_STALL_CNT_EN defined:
  - stall_cnt_o increments on every cycle with out_valid_o=1 and out_ready_i=0.
  - It saturates at 2^CNT_W−1.
  - It is cleared only by reset; flush does not clear it.
- Undefined: the port is still present and tied to 0, and no counter logic is synthesised.

## Structure
- Shared package pipe_pkg holds:
  - the stage state encoding: EMPTY=2'b00, BUSY=2'b01, FULL=2'b11
  - a common WIDTH default constant
- One sub-module, pipe_skid_stage, implements the skid state machine and flush. pipe_elastic_reg instantiates DEPTH copies in a generate loop, with ready chained backwards and valid/data chained forwards.

## Test plan
- **Reset.** Drive rst_i=0 mid-stream with 2 entries held → outputs read 0/1/0/0 immediately. After release, the first push of 0xA5A5A5A5 appears after DEPTH cycles.
- **Streaming.** DEPTH=3, out_ready_i=1, push 0x1..0x10 on consecutive cycles → same sequence out, first at cycle 3, no gaps.
- **Back-pressure fill.** DEPTH=2, out_ready_i=0, push continuously → exactly 4 accepts, then in_ready_o=0. Release → outputs 1,2,3,4 in order, no loss.
- **Simultaneous flush.** Assert flush_i with in_valid_i=1 (data 0x55) while full → next cycle out_valid_o=0, out_data_o=0, and 0x55 is never output.
- **Random handshake.** Random in_valid_i and out_ready_i over 10k cycles, DEPTH∈{1,4} → scoreboard matches order and count exactly.
- **Counter saturation (macro on).** CNT_W=4, hold out_valid_o with out_ready_i=0 for 20 cycles → stall_cnt_o=15. With the macro off, stall_cnt_o reads 0 throughout.
